mux_scan: RTL and testbench

- Parametrised registered N-channel multiplexor with two modes: manual selection and automatic round-robin scan.
- In scan mode, each unmasked channel is held for a programmable dwell time.
- The output is registered and tagged with the active channel index and a one-cycle valid strobe on every channel change.
- Sits between multi-source data buses and a single downstream consumer, e.g. a display driver or serial transmitter.

---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_next.sv | 26 ++
 rtl/mux_scan.sv | 152 +++++++++++++++
 tb/tb_mux_scan.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared state and mode encodings for mux_scan
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scan_next.sv
// rtl/mux_scan_next.sv - wrap-around search for the next unmasked channel after cur
module mux_scan_next #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [SEL_W-1:0]    cur,
  input  logic [CHANNELS-1:0] mask,
  output logic [SEL_W-1:0]    nxt,
  output logic                found
);

  // Walk offsets from farthest to nearest so the closest hit is assigned last;
  // offset CHANNELS lands back on cur itself.
  always_comb begin
    nxt   = cur;
    found = |mask;
    for (int off = CHANNELS; off >= 1; off--) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if ((c == (int'(cur) + off) % CHANNELS) && mask[c]) begin
          nxt = SEL_W'(c);
        end
      end
    end
  end

endmodule

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - registered N-channel mux with manual select and round-robin scan
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Enable,
  input  logic                      i_Mode,
  input  logic [SEL_W-1:0]          i_Sel,
  input  logic [CHANNELS-1:0]       i_Mask,
  input  logic [CHANNELS*WIDTH-1:0] i_Datos,
  output logic [WIDTH-1:0]          o_Salida,
  output logic [SEL_W-1:0]          o_Canal,
  output logic                      o_Valid
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              parked, parked_d;
  logic [WIDTH-1:0]  salida_d;
  logic [SEL_W-1:0]  canal_d;
  logic              valid_d;
  logic [SEL_W-1:0]  search_cur, nxt;
  logic              found;
  logic [WIDTH-1:0]  sel_data, nxt_data, cur_data;
  logic              cur_in_mask, dwell_done, go_manual, go_scan;

  function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] k,
                                            input logic [CHANNELS*WIDTH-1:0] d);
    pick = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (k == SEL_W'(c)) pick = d[c*WIDTH +: WIDTH];
    end
  endfunction

  // Outside SCAN, searching after the last index yields the lowest unmasked channel.
  assign search_cur = (state == SCAN) ? o_Canal : SEL_W'(CHANNELS - 1);

  mux_scan_next #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_next (
    .cur   (search_cur),
    .mask  (i_Mask),
    .nxt   (nxt),
    .found (found)
  );

  always_comb begin
    sel_data    = pick(i_Sel, i_Datos);
    nxt_data    = pick(nxt, i_Datos);
    cur_data    = pick(o_Canal, i_Datos);
    dwell_done  = (cnt == CNT_W'(DWELL - 1));
    cur_in_mask = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (o_Canal == SEL_W'(c) && i_Mask[c]) cur_in_mask = 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    parked_d  = parked;
    salida_d  = o_Salida;
    canal_d   = o_Canal;
    valid_d   = 1'b0;
    go_manual = 1'b0;
    go_scan   = 1'b0;
    if (!i_Enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          go_manual = (i_Mode == MODE_MANUAL);
          go_scan   = (i_Mode == MODE_SCAN);
        end
        MANUAL: begin
          if (i_Mode == MODE_SCAN) begin
            go_scan = 1'b1;
          end else begin
            canal_d  = i_Sel;
            salida_d = sel_data;
            valid_d  = (i_Sel != o_Canal);
          end
        end
        SCAN: begin
          if (i_Mode == MODE_MANUAL) begin
            go_manual = 1'b1;
          end else if (!found) begin
            parked_d = 1'b1;
            cnt_d    = '0;
          end else if (parked || dwell_done || !cur_in_mask) begin
            // Parked after an all-zero mask always re-selects, even if cur is unmasked again.
            canal_d  = nxt;
            salida_d = nxt_data;
            valid_d  = 1'b1;
            cnt_d    = '0;
            parked_d = 1'b0;
          end else begin
            cnt_d    = cnt + CNT_W'(1);
            salida_d = cur_data;
          end
        end
        default: state_d = IDLE;
      endcase
      if (go_manual) begin
        state_d  = MANUAL;
        canal_d  = i_Sel;
        salida_d = sel_data;
        valid_d  = 1'b1;
        cnt_d    = '0;
        parked_d = 1'b0;
      end
      if (go_scan) begin
        state_d = SCAN;
        cnt_d   = '0;
        if (found) begin
          canal_d  = nxt;
          salida_d = nxt_data;
          valid_d  = 1'b1;
          parked_d = 1'b0;
        end else begin
          parked_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      parked   <= 1'b0;
      o_Salida <= '0;
      o_Canal  <= '0;
      o_Valid  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      parked   <= parked_d;
      o_Salida <= salida_d;
      o_Canal  <= canal_d;
      o_Valid  <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - randomized and directed bench for mux_scan against a cycle model
module tb_mux_scan;

  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [1:0]  sel;
  logic [3:0]  mask;
  logic [3:0]  d [4];
  logic [15:0] datos;
  logic [3:0]  o_Salida;
  logic [1:0]  o_Canal;
  logic        o_Valid;

  int total = 0;
  int bad   = 0;

  // model of the observable behaviour
  int         m_mode_st;  // 0 idle, 1 manual, 2 scan
  int         m_held;     // cycles the current scan channel has been shown
  bit         m_park;
  logic [3:0] m_sal;
  logic [1:0] m_can;
  logic       m_val;

  assign datos = {d[3], d[2], d[1], d[0]};

  always #5 clk = ~clk;

  mux_scan dut (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Enable (en),
    .i_Mode   (mode),
    .i_Sel    (sel),
    .i_Mask   (mask),
    .i_Datos  (datos),
    .o_Salida (o_Salida),
    .o_Canal  (o_Canal),
    .o_Valid  (o_Valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] next_after(input logic [1:0] cur, input logic [3:0] mk);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (int'(cur) + k) % 4;
      if (mk[idx]) return 2'(idx);
    end
    return cur;
  endfunction

  task automatic select(input logic [1:0] ch);
    m_can  = ch;
    m_sal  = d[ch];
    m_val  = 1'b1;
    m_held = 1;
    m_park = 1'b0;
  endtask

  task automatic model_step();
    m_val = 1'b0;
    if (rst) begin
      m_mode_st = 0; m_held = 0; m_park = 0; m_sal = '0; m_can = '0;
    end else if (!en) begin
      m_mode_st = 0;
    end else if (m_mode_st == 0 || (m_mode_st == 1) == mode) begin
      m_mode_st = mode ? 2 : 1;
      if (!mode) select(sel);
      else if (mask == 0) m_park = 1'b1;
      else select(next_after(2'd3, mask));
    end else if (m_mode_st == 1) begin
      m_val = (sel != m_can);
      m_can = sel;
      m_sal = d[sel];
    end else if (mask == 0) begin
      m_park = 1'b1;
    end else if (m_park || m_held >= DWELL || !mask[m_can]) begin
      select(next_after(m_can, mask));
    end else begin
      m_held++;
      m_sal = d[m_can];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    check("salida", o_Salida, m_sal);
    check("canal", o_Canal, m_can);
    check("valid", o_Valid, m_val);
  endtask

  task automatic wait_ch(input logic [1:0] ch);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cyc();
      if (o_Valid && o_Canal == ch) ok = 1;
    end
    check("wait_ch", ok, 1);
  endtask

  initial begin
    int pulses;
    bit seen_skip;
    rst = 1; en = 0; mode = 0; sel = 0; mask = 4'hF;
    d[0] = 4'h1; d[1] = 4'h2; d[2] = 4'h4; d[3] = 4'h8;
    cyc(); cyc();
    check("rst_salida", o_Salida, 0);
    check("rst_canal", o_Canal, 0);
    check("rst_valid", o_Valid, 0);

    // manual walk
    rst = 0; en = 1; mode = 0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        cyc();
        if (i == 0) check("t1_sal", o_Salida, 32'd1 << s);
        pulses += int'(o_Valid);
      end
      check("t1_pulses", pulses, 1);
    end

    // full scan
    mode = 1;
    for (int i = 0; i <= 32; i++) begin
      cyc();
      check("t2_valid", o_Valid, (i % 8 == 0));
      if (i % 8 == 0) begin
        check("t2_can", o_Canal, (i / 8) % 4);
        check("t2_sal", o_Salida, 32'd1 << ((i / 8) % 4));
      end
    end

    // masked scan
    mask = 4'b1010;
    seen_skip = 0;
    for (int i = 0; i <= 24; i++) begin
      cyc();
      if (o_Canal == 0 || o_Canal == 2) seen_skip = 1;
      if (i % 8 == 0) begin
        check("t3_can", o_Canal, ((i / 8) % 2) ? 3 : 1);
        check("t3_sal", o_Salida, ((i / 8) % 2) ? 8 : 2);
      end
    end
    check("t3_skip", seen_skip, 0);

    // all-zero mask freezes, then resumes after current channel
    wait_ch(2'd1);
    mask = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t4_can", o_Canal, 1);
      check("t4_sal", o_Salida, 2);
      check("t4_valid", o_Valid, 0);
    end
    mask = 4'b0001;
    cyc();
    check("t4_resume_can", o_Canal, 0);
    check("t4_resume_sal", o_Salida, 1);
    check("t4_resume_valid", o_Valid, 1);

    // reset mid-dwell
    mask = 4'hF;
    wait_ch(2'd2);
    repeat (4) cyc();
    rst = 1;
    cyc();
    check("t5_sal", o_Salida, 0);
    check("t5_can", o_Canal, 0);
    check("t5_valid", o_Valid, 0);
    rst = 0;
    cyc();
    check("t5_restart_can", o_Canal, 0);
    check("t5_restart_valid", o_Valid, 1);

    // scan -> manual, then data change without strobe
    wait_ch(2'd3);
    repeat (5) cyc();
    mode = 0; sel = 2'd1;
    cyc();
    check("t6_can", o_Canal, 1);
    check("t6_sal", o_Salida, 2);
    check("t6_valid", o_Valid, 1);
    d[1] = 4'hA;
    cyc();
    check("t6_data_sal", o_Salida, 4'hA);
    check("t6_data_valid", o_Valid, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom % 60 == 0);
      en  = ($urandom % 12 != 0);
      if ($urandom % 25 == 0) mode = ~mode;
      if ($urandom % 6 == 0) sel = 2'($urandom);
      if ($urandom % 15 == 0) mask = ($urandom % 4 == 0) ? 4'h0 : 4'($urandom);
      if ($urandom % 4 == 0) d[$urandom % 4] = 4'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
